// File: rtl/cic_ctrl_pkg.sv
// cic_ctrl_pkg: shared state encoding and ratio limit for the CIC run-time sequencer
package cic_ctrl_pkg;
    typedef enum logic [1:0] {CLEAR, SETTLE, RUN} cic_ctrl_state_t;
    localparam int CIC_MIN_RATE = 2;
endpackage

// File: rtl/cic_phase_cnt.sv
// cic_phase_cnt: wrap counter over accepted samples, flags the sample that lands on the terminal value
module cic_phase_cnt #(
    parameter int RW = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [RW-1:0] i_term,
    output logic          o_hit
);
    logic [RW-1:0] cnt_q, cnt_d;
    always_comb begin
        o_hit = i_en && (cnt_q == i_term);
        cnt_d = i_clr ? '0 : !i_en ? cnt_q : o_hit ? '0 : cnt_q + RW'(1);
    end
    always_ff @(posedge i_clk) begin
        cnt_q <= !i_reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/cic_ctrl.sv
// cic_ctrl: CIC clear/settle/run sequencer with ratio config; CIC_CTRL_DROP_CNT_EN adds the CLEAR drop counter
module cic_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int RW        = 16,
    parameter int M         = 3,
    parameter int R_DEFAULT = 100,
    parameter int CW        = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_cfg_valid,
    input  logic [RW-1:0] i_cfg_rate,
    output logic          o_cfg_ready,
    output logic          o_cfg_err,
    output logic          o_clear,
    output logic          o_int_ce,
    output logic          o_dec_ce,
    output logic          o_comb_ce,
    output logic          o_out_en,
    output logic [RW-1:0] o_rate,
    output logic [CW-1:0] o_drop_cnt
);
    localparam int SW = $clog2(M + 1);
    cic_ctrl_state_t state_q, state_d;
    logic [RW-1:0] rate_q, rate_d;
    logic [SW-1:0] settle_q, settle_d;
    logic int_ce_q, int_ce_d, dec_ce_q, dec_ce_d, comb_ce_q, comb_ce_d, cfg_err_q, cfg_err_d;
    logic active, accept, rate_ok, load, settled, hit;
    assign active = state_q != CLEAR;
    cic_phase_cnt #(.RW(RW)) u_phase (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clr  (!active),
        .i_en   (active && i_ce),
        .i_term (rate_q - RW'(1)),
        .o_hit  (hit)
    );
    // The sample in an accept cycle still runs under the old ratio; CLEAR follows.
    always_comb begin
        accept    = i_cfg_valid && active;
        rate_ok   = i_cfg_rate >= RW'(CIC_MIN_RATE);
        load      = accept && rate_ok;
        settled   = state_q == SETTLE && comb_ce_q && settle_q == SW'(M - 1);
        rate_d    = load ? i_cfg_rate : rate_q;
        cfg_err_d = accept && !rate_ok;
        int_ce_d  = active && i_ce;
        dec_ce_d  = hit;
        comb_ce_d = dec_ce_q;
        settle_d  = !active ? '0 : (state_q == SETTLE && comb_ce_q) ? settle_q + SW'(1) : settle_q;
        state_d   = load ? CLEAR : !active ? SETTLE : settled ? RUN : state_q;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= CLEAR;
            rate_q    <= RW'(R_DEFAULT);
            settle_q  <= '0;
            int_ce_q  <= 1'b0;
            dec_ce_q  <= 1'b0;
            comb_ce_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rate_q    <= rate_d;
            settle_q  <= settle_d;
            int_ce_q  <= int_ce_d;
            dec_ce_q  <= dec_ce_d;
            comb_ce_q <= comb_ce_d;
            cfg_err_q <= cfg_err_d;
        end
    end
    assign o_cfg_ready = active;
    assign o_clear     = !active;
    assign o_out_en    = state_q == RUN;
    assign o_cfg_err   = cfg_err_q;
    assign o_int_ce    = int_ce_q;
    assign o_dec_ce    = dec_ce_q;
    assign o_comb_ce   = comb_ce_q;
    assign o_rate      = rate_q;
`ifdef CIC_CTRL_DROP_CNT_EN
    logic [CW-1:0] drop_q, drop_d;
    always_comb begin
        drop_d = (!active && i_ce && !(&drop_q)) ? drop_q + CW'(1) : drop_q;
    end
    always_ff @(posedge i_clk) begin
        drop_q <= !i_reset ? '0 : drop_d;
    end
    assign o_drop_cnt = drop_q;
`else
    assign o_drop_cnt = '0;
`endif
endmodule

// File: tb/tb_cic_ctrl.sv
// tb_cic_ctrl: directed bench with a sample-count model of the CIC sequencer checked every cycle
module tb_cic_ctrl;
`ifdef CIC_CTRL_DROP_CNT_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif
    localparam int M = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0, ce = 1'b0, cfg_valid = 1'b0;
    logic [15:0] cfg_rate = '0;
    logic cfg_ready, cfg_err, clear, int_ce, dec_ce, comb_ce, out_en;
    logic [15:0] rate, drop_cnt;
    int vectors = 0, miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    int m_mode, m_rate, m_samples, m_combs, m_drop;
    bit m_err;
    bit e_int[0:8191], e_dec[0:8191], e_comb[0:8191];

    always #5 clk = ~clk;

    cic_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_ce(ce), .i_cfg_valid(cfg_valid), .i_cfg_rate(cfg_rate),
        .o_cfg_ready(cfg_ready), .o_cfg_err(cfg_err), .o_clear(clear), .o_int_ce(int_ce),
        .o_dec_ce(dec_ce), .o_comb_ce(comb_ce), .o_out_en(out_en), .o_rate(rate), .o_drop_cnt(drop_cnt)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    // Modes: 0 clear, 1 settle, 2 run; decimation follows from samples-since-clear modulo the ratio.
    task automatic model_step(input bit s_ce, input bit s_v, input int s_r, input bit s_rst_n);
        int nm;
        cyc++;
        if (!s_rst_n) begin
            m_mode = 0; m_rate = 100; m_samples = 0; m_combs = 0; m_err = 0; m_drop = 0;
            e_int[cyc] = 0; e_dec[cyc] = 0; e_comb[cyc] = 0; e_comb[cyc+1] = 0;
            return;
        end
        m_err = 0;
        nm = m_mode;
        if (m_mode == 0) begin
            if (DROP_EN == 1 && s_ce && m_drop < 65535) m_drop++;
            m_samples = 0; m_combs = 0; nm = 1;
        end else begin
            if (s_ce) begin
                e_int[cyc] = 1;
                m_samples++;
                if (m_samples % m_rate == 0) begin
                    e_dec[cyc] = 1;
                    e_comb[cyc+1] = 1;
                end
            end
            if (m_mode == 1 && e_comb[cyc-1]) begin
                m_combs++;
                if (m_combs == M) nm = 2;
            end
            if (s_v) begin
                if (s_r >= 2) begin m_rate = s_r; nm = 0; end
                else m_err = 1;
            end
        end
        m_mode = nm;
    endtask

    task automatic tick(input bit t_ce, input bit t_v, input int t_r, input bit t_rst_n);
        ce = t_ce; cfg_valid = t_v; cfg_rate = 16'(t_r); rst_n = t_rst_n;
        @(posedge clk);
        model_step(t_ce, t_v, t_r, t_rst_n);
        chk_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("clear", clear, m_mode == 0);
            chk("out_en", out_en, m_mode == 2);
            chk("cfg_ready", cfg_ready, m_mode != 0);
            chk("cfg_err", cfg_err, m_err);
            chk("int_ce", int_ce, e_int[cyc]);
            chk("dec_ce", dec_ce, e_dec[cyc]);
            chk("comb_ce", comb_ce, e_comb[cyc]);
            chk("rate", rate, m_rate);
            chk("drop_cnt", drop_cnt, m_drop);
        end
    end

    task automatic run_from_reset(input string tag);
        int first_dec, rise, ndec;
        tick(1, 0, 0, 0);
        chk({tag, "_rst_rate"}, rate, 100);
        chk({tag, "_rst_clear"}, clear, 1);
        chk({tag, "_rst_en"}, {int_ce, dec_ce, comb_ce, out_en, cfg_ready}, 0);
        tick(1, 0, 0, 0);
        first_dec = -1; rise = -1; ndec = 0;
        for (int r = 1; r <= 310; r++) begin
            tick(1, 0, 0, 1);
            if (dec_ce === 1'b1) begin ndec++; if (first_dec < 0) first_dec = r; end
            if (out_en === 1'b1 && rise < 0) rise = r;
        end
        chk({tag, "_first_dec"}, first_dec, 101);
        chk({tag, "_ndec"}, ndec, 3);
        chk({tag, "_out_en_rise"}, rise, 303);
    endtask

    initial begin
        int first_dec, rise, ndec, nclr;
        run_from_reset("pwr");
        // ratio change in RUN
        tick(0, 1, 4, 1);
        chk("p2_clear", clear, 1);
        chk("p2_ready", cfg_ready, 0);
        chk("p2_rate", rate, 4);
        first_dec = -1; rise = -1; ndec = 0;
        for (int r = 1; r <= 20; r++) begin
            tick(1, 0, 0, 1);
            if (dec_ce === 1'b1) begin ndec++; if (first_dec < 0) first_dec = r; end
            if (out_en === 1'b1 && rise < 0) rise = r;
        end
        chk("p2_first_dec", first_dec, 5);
        chk("p2_ndec", ndec, 4);
        chk("p2_out_en_rise", rise, 15);
        // invalid ratios
        tick(0, 1, 1, 1);
        chk("p3_err1", cfg_err, 1);
        chk("p3_rate1", rate, 4);
        chk("p3_out_en1", out_en, 1);
        tick(0, 0, 0, 1);
        chk("p3_err_gap", cfg_err, 0);
        tick(0, 1, 0, 1);
        chk("p3_err0", cfg_err, 1);
        chk("p3_rate0", rate, 4);
        chk("p3_out_en0", out_en, 1);
        // accept and sample in the same cycle
        tick(1, 1, 6, 1);
        chk("p4_int_ce", int_ce, 1);
        chk("p4_clear", clear, 1);
        chk("p4_rate", rate, 6);
        tick(1, 0, 0, 1);
        chk("p4_dropped", int_ce, 0);
        chk("p4_drop_cnt", drop_cnt, DROP_EN * 3);
        for (int r = 0; r < 30; r++) tick(1, 0, 0, 1);
        chk("p4_run", out_en, 1);
        // reset in SETTLE with an in-flight terminal sample
        tick(0, 1, 4, 1);
        for (int r = 0; r < 4; r++) tick(1, 0, 0, 1);
        chk("p5_settle", {clear, out_en}, 0);
        run_from_reset("mid");
        // back-to-back configs across SETTLE cycles, valid held high
        nclr = 0;
        tick(0, 1, 8, 1);  nclr += clear; chk("p6_ready_a", cfg_ready, 0);
        tick(0, 1, 9, 1);  nclr += clear; chk("p6_rate_a", rate, 8);
        tick(0, 1, 5, 1);  nclr += clear; chk("p6_ready_b", cfg_ready, 0);
        tick(0, 1, 10, 1); nclr += clear; chk("p6_rate_b", rate, 5);
        tick(0, 1, 7, 1);  nclr += clear; chk("p6_ready_c", cfg_ready, 0);
        tick(0, 0, 0, 1);  nclr += clear;
        chk("p6_nclear", nclr, 3);
        for (int r = 0; r < 30; r++) tick(1, 0, 0, 1);
        chk("p6_rate", rate, 7);
        chk("p6_run", out_en, 1);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
